mux_arb_n: RTL and testbench
============================

Name: mux_arb_n

Overview:
Parametrised N-input, WIDTH-bit multiplexer with per-channel valid/ready handshakes and a registered output stage. It is the successor to the 2:1 combinational muxes: selection comes from an internal arbiter rather than an external sel input. The arbiter runs in fixed-priority or round-robin mode. The block sits between several producer streams and a single consumer, and sustains one transfer per cycle.

Parameters:
NUM_INPUTS, 4, number of input channels (>=1)
WIDTH, 8, data width per channel in bits
MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
SEL_W, max(1,$clog2(NUM_INPUTS)), width of out_sel (derived localparam, not overridable)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_data  input  NUM_INPUTS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  NUM_INPUTS  channel i has data
in_ready  output  NUM_INPUTS  channel i's data is accepted this cycle (combinational)
out_data  output  WIDTH  registered selected data
out_sel  output  SEL_W  registered index of the channel that produced out_data
out_valid  output  1  out_data/out_sel hold a transfer
out_ready  input  1  consumer accepts the output this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n; sampled only on a clk rising edge.
- Reset values: out_valid=0, out_data=0, out_sel=0, round-robin pointer=0 (channel 0 highest priority).
- in_ready is 0 in any cycle where rst_n=0.
- Load enable: load_en = !out_valid || out_ready. Output register is empty or draining this cycle.
- Grant: when load_en=1 and |in_valid, exactly one channel g is granted, combinationally from current in_valid.
  - MODE=0: g = lowest index i with in_valid[i]=1.
  - MODE=1: g = first i with in_valid[i]=1, searching ptr, ptr+1, ... modulo NUM_INPUTS.
- in_ready[g]=1 only when load_en=1 and the channel is granted; all other in_ready bits are 0. At most one in_ready bit is high per cycle.
- Transfer in: on the clock edge with in_valid[g] && in_ready[g]:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - MODE=1 only: ptr <= (g+1) mod NUM_INPUTS, with wrap from NUM_INPUTS-1 back to 0.
- Latency: exactly 1 cycle from input acceptance to out_valid.
- Throughput: 1 transfer per cycle when out_ready is held at 1.
- Drain with no new data: load_en=1 and in_valid=0 → out_valid <= 0. out_data and out_sel keep their last values (don't-care while out_valid=0).
- Backpressure: out_valid=1 && out_ready=0 means out_data, out_sel, out_valid and ptr are all held; every in_ready bit is 0.
- Simultaneous drain and load: an output being consumed in the same cycle a new grant occurs is replaced without a bubble.
- Pointer update: ptr changes only on an accepted transfer. Idle cycles and stalled cycles leave it unchanged. In MODE=0, ptr stays at 0.
- Input validity: in_valid may deassert without having been granted; no grant is ever given to a channel whose in_valid is 0.
- NUM_INPUTS=1: degenerates to a registered pipeline stage with out_sel constant 0.
- Reset mid-operation: any held output is discarded (out_valid=0 on the next cycle) and ptr returns to 0. No input is accepted during the reset cycle.
- No combinational path from out_ready to out_data.
- Combinational path from out_ready to in_ready is permitted.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with in_valid=4'b1111 and out_ready=1 → in_ready=0 throughout reset; out_valid=0 and out_sel=0 on the cycle after release.
2. Single source (MODE=1, N=4, W=8): in_valid=4'b0100, channel 2 data=8'hA5, out_ready=1 → in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_sel=2. With data incremented each cycle, a new value appears every cycle with no bubble.
3. Round-robin fairness (MODE=1): in_valid=4'b1111 held, channel i data=8'h10+i, out_ready=1 for 8 cycles → out_sel sequence 0,1,2,3,0,1,2,3 and out_data 10,11,12,13,10,...; with in_valid=4'b1010 → out_sel alternates 1,3,1,3.
4. Fixed priority (MODE=0): in_valid=4'b1110 for 4 cycles → out_sel=1 every cycle. Dropping in_valid[1] → out_sel=2.
5. Backpressure (MODE=1): out_valid=1, out_sel=1, out_data=8'h11, then out_ready=0 for 3 cycles with all in_valid=1 → outputs stable and in_ready=0 for those cycles. out_ready=1 → next out_sel=2, confirming ptr did not advance during the stall.
6. Reset mid-stream (MODE=1): after grants to channels 0 and 1 (ptr=2) with out_valid=1, pulse rst_n=0 for 1 cycle → out_valid=0 the next cycle. With all in_valid=1 afterwards, the first out_sel is 0.

Source files
------------

// File: rtl/mux_arb_n.sv
// N-input stream multiplexer with an internal fixed-priority or round-robin arbiter
// and a single registered output stage carrying data and source index.
module mux_arb_n #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MODE       = 1,
  localparam int unsigned SEL_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]       in_valid,
  output logic [NUM_INPUTS-1:0]       in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [SEL_W-1:0]            out_sel,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam logic [SEL_W:0]   NumW = (SEL_W + 1)'(NUM_INPUTS);
  localparam logic [SEL_W-1:0] Last = SEL_W'(NUM_INPUTS - 1);

  logic [WIDTH-1:0] ch_data [NUM_INPUTS];

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_en;
  logic             xfer;
  logic [SEL_W-1:0] base;
  logic [SEL_W:0]   sum;
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_found;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Output slot is free if empty or being consumed this cycle.
  assign load_en = !out_valid_q || out_ready;
  assign base    = (MODE == 1) ? ptr_q : '0;

  // Search from base upward with wrap; first valid channel wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      sum = {1'b0, base} + (SEL_W + 1)'(k);
      if (sum >= NumW) begin
        sum = sum - NumW;
      end
      cand = sum[SEL_W-1:0];
      if (!grant_found && in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign xfer     = rst_n && load_en && grant_found;
  assign in_ready = xfer ? (NUM_INPUTS'(1) << grant_idx) : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = ch_data[grant_idx];
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
      if (MODE == 1) begin
        ptr_d = (grant_idx == Last) ? '0 : grant_idx + SEL_W'(1);
      end
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed vector bench for mux_arb_n: a round-robin and a fixed-priority instance
// share the same input stimulus, each with its own hand-computed expectations.
module tb_mux_arb_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  rr_ready, fp_ready;
  logic [7:0]  rr_data, fp_data;
  logic [1:0]  rr_sel, fp_sel;
  logic        rr_valid, fp_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_arb_n #(.NUM_INPUTS(4), .WIDTH(8), .MODE(1)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (rr_ready),
    .out_data  (rr_data),
    .out_sel   (rr_sel),
    .out_valid (rr_valid),
    .out_ready (out_ready)
  );

  mux_arb_n #(.NUM_INPUTS(4), .WIDTH(8), .MODE(0)) u_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (fp_ready),
    .out_data  (fp_data),
    .out_sel   (fp_sel),
    .out_valid (fp_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  rr_rdy;
    logic        rr_ov;
    logic [7:0]  rr_od;
    logic [1:0]  rr_os;
    logic [3:0]  fp_rdy;
    logic        fp_ov;
    logic [7:0]  fp_od;
    logic [1:0]  fp_os;
  } vec_t;

  localparam logic [31:0] D0 = 32'h1312_1110;
  localparam int NVEC = 37;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [31:0] d,
                              input logic o,
                              input logic [3:0] rrr, input logic rrv, input logic [7:0] rrd,
                              input logic [1:0] rrs,
                              input logic [3:0] fpr, input logic fpv, input logic [7:0] fpd,
                              input logic [1:0] fps);
    vec_t x;
    x.rst_n = r;   x.valid = v;   x.data = d;    x.ordy = o;
    x.rr_rdy = rrr; x.rr_ov = rrv; x.rr_od = rrd; x.rr_os = rrs;
    x.fp_rdy = fpr; x.fp_ov = fpv; x.fp_od = fpd; x.fp_os = fps;
    return x;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check in_ready before the edge and registers after it.
  // Data/sel are compared whenever a valid is expected, and also right after reset.
  task automatic step(input int idx, input vec_t v);
    rst_n     = v.rst_n;
    in_valid  = v.valid;
    in_data   = v.data;
    out_ready = v.ordy;
    #1;
    check("rr_in_ready", idx, 32'(rr_ready), 32'(v.rr_rdy));
    check("fp_in_ready", idx, 32'(fp_ready), 32'(v.fp_rdy));
    @(posedge clk);
    #1;
    check("rr_out_valid", idx, 32'(rr_valid), 32'(v.rr_ov));
    check("fp_out_valid", idx, 32'(fp_valid), 32'(v.fp_ov));
    if (v.rr_ov || !v.rst_n) begin
      check("rr_out_data", idx, 32'(rr_data), 32'(v.rr_od));
      check("rr_out_sel", idx, 32'(rr_sel), 32'(v.rr_os));
    end
    if (v.fp_ov || !v.rst_n) begin
      check("fp_out_data", idx, 32'(fp_data), 32'(v.fp_od));
      check("fp_out_sel", idx, 32'(fp_sel), 32'(v.fp_os));
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Reset with every channel requesting.
    vecs[0]  = mk(0, 4'b1111, D0, 1,            4'b0000, 0, 8'h00, 0, 4'b0000, 0, 8'h00, 0);
    vecs[1]  = mk(0, 4'b1111, D0, 1,            4'b0000, 0, 8'h00, 0, 4'b0000, 0, 8'h00, 0);
    // Single source on channel 2, data changing every cycle.
    vecs[2]  = mk(1, 4'b0100, 32'h13A5_1110, 1, 4'b0100, 1, 8'hA5, 2, 4'b0100, 1, 8'hA5, 2);
    vecs[3]  = mk(1, 4'b0100, 32'h13A6_1110, 1, 4'b0100, 1, 8'hA6, 2, 4'b0100, 1, 8'hA6, 2);
    vecs[4]  = mk(1, 4'b0100, 32'h13A7_1110, 1, 4'b0100, 1, 8'hA7, 2, 4'b0100, 1, 8'hA7, 2);
    vecs[5]  = mk(0, 4'b1111, D0, 1,            4'b0000, 0, 8'h00, 0, 4'b0000, 0, 8'h00, 0);
    // All channels requesting: rotation vs. fixed channel 0.
    vecs[6]  = mk(1, 4'b1111, D0, 1,            4'b0001, 1, 8'h10, 0, 4'b0001, 1, 8'h10, 0);
    vecs[7]  = mk(1, 4'b1111, D0, 1,            4'b0010, 1, 8'h11, 1, 4'b0001, 1, 8'h10, 0);
    vecs[8]  = mk(1, 4'b1111, D0, 1,            4'b0100, 1, 8'h12, 2, 4'b0001, 1, 8'h10, 0);
    vecs[9]  = mk(1, 4'b1111, D0, 1,            4'b1000, 1, 8'h13, 3, 4'b0001, 1, 8'h10, 0);
    vecs[10] = mk(1, 4'b1111, D0, 1,            4'b0001, 1, 8'h10, 0, 4'b0001, 1, 8'h10, 0);
    vecs[11] = mk(1, 4'b1111, D0, 1,            4'b0010, 1, 8'h11, 1, 4'b0001, 1, 8'h10, 0);
    vecs[12] = mk(1, 4'b1111, D0, 1,            4'b0100, 1, 8'h12, 2, 4'b0001, 1, 8'h10, 0);
    vecs[13] = mk(1, 4'b1111, D0, 1,            4'b1000, 1, 8'h13, 3, 4'b0001, 1, 8'h10, 0);
    // Sparse requests 1 and 3.
    vecs[14] = mk(1, 4'b1010, D0, 1,            4'b0010, 1, 8'h11, 1, 4'b0010, 1, 8'h11, 1);
    vecs[15] = mk(1, 4'b1010, D0, 1,            4'b1000, 1, 8'h13, 3, 4'b0010, 1, 8'h11, 1);
    vecs[16] = mk(1, 4'b1010, D0, 1,            4'b0010, 1, 8'h11, 1, 4'b0010, 1, 8'h11, 1);
    vecs[17] = mk(1, 4'b1010, D0, 1,            4'b1000, 1, 8'h13, 3, 4'b0010, 1, 8'h11, 1);
    // Fixed priority picks lowest requester; then channel 1 drops out.
    vecs[18] = mk(1, 4'b1110, D0, 1,            4'b0010, 1, 8'h11, 1, 4'b0010, 1, 8'h11, 1);
    vecs[19] = mk(1, 4'b1110, D0, 1,            4'b0100, 1, 8'h12, 2, 4'b0010, 1, 8'h11, 1);
    vecs[20] = mk(1, 4'b1100, D0, 1,            4'b1000, 1, 8'h13, 3, 4'b0100, 1, 8'h12, 2);
    vecs[21] = mk(1, 4'b0000, D0, 1,            4'b0000, 0, 8'h00, 0, 4'b0000, 0, 8'h00, 0);
    // Backpressure: hold channel 1's word, then the round-robin resumes at 2.
    vecs[22] = mk(1, 4'b0010, D0, 1,            4'b0010, 1, 8'h11, 1, 4'b0010, 1, 8'h11, 1);
    vecs[23] = mk(1, 4'b1111, D0, 0,            4'b0000, 1, 8'h11, 1, 4'b0000, 1, 8'h11, 1);
    vecs[24] = mk(1, 4'b1111, D0, 0,            4'b0000, 1, 8'h11, 1, 4'b0000, 1, 8'h11, 1);
    vecs[25] = mk(1, 4'b1111, D0, 0,            4'b0000, 1, 8'h11, 1, 4'b0000, 1, 8'h11, 1);
    vecs[26] = mk(1, 4'b1111, D0, 1,            4'b0100, 1, 8'h12, 2, 4'b0001, 1, 8'h10, 0);
    // Reset mid-stream with ptr=2, then restart from channel 0.
    vecs[27] = mk(1, 4'b1111, D0, 1,            4'b1000, 1, 8'h13, 3, 4'b0001, 1, 8'h10, 0);
    vecs[28] = mk(1, 4'b1111, D0, 1,            4'b0001, 1, 8'h10, 0, 4'b0001, 1, 8'h10, 0);
    vecs[29] = mk(1, 4'b1111, D0, 1,            4'b0010, 1, 8'h11, 1, 4'b0001, 1, 8'h10, 0);
    vecs[30] = mk(0, 4'b1111, D0, 1,            4'b0000, 0, 8'h00, 0, 4'b0000, 0, 8'h00, 0);
    vecs[31] = mk(1, 4'b1111, D0, 1,            4'b0001, 1, 8'h10, 0, 4'b0001, 1, 8'h10, 0);
    // Stall vs. empty register with out_ready low.
    vecs[32] = mk(1, 4'b0100, D0, 0,            4'b0000, 1, 8'h10, 0, 4'b0000, 1, 8'h10, 0);
    vecs[33] = mk(1, 4'b0000, D0, 1,            4'b0000, 0, 8'h00, 0, 4'b0000, 0, 8'h00, 0);
    vecs[34] = mk(1, 4'b0100, D0, 0,            4'b0100, 1, 8'h12, 2, 4'b0100, 1, 8'h12, 2);
    vecs[35] = mk(1, 4'b1111, D0, 0,            4'b0000, 1, 8'h12, 2, 4'b0000, 1, 8'h12, 2);
    vecs[36] = mk(1, 4'b0000, D0, 1,            4'b0000, 0, 8'h00, 0, 4'b0000, 0, 8'h00, 0);

    for (int i = 0; i < NVEC; i++) begin
      step(i, vecs[i]);
    end

    // Channel 1 requests only while stalled and withdraws; channel 3 must win after.
    // rr ptr is 3 here, so channel 0 is found by wrapping.
    step(100, mk(1, 4'b0001, D0, 1, 4'b0001, 1, 8'h10, 0, 4'b0001, 1, 8'h10, 0));
    step(101, mk(1, 4'b0010, D0, 0, 4'b0000, 1, 8'h10, 0, 4'b0000, 1, 8'h10, 0));
    step(102, mk(1, 4'b1000, D0, 1, 4'b1000, 1, 8'h13, 3, 4'b1000, 1, 8'h13, 3));
    step(103, mk(1, 4'b0000, D0, 1, 4'b0000, 0, 8'h00, 0, 4'b0000, 0, 8'h00, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
